// File: rtl/cv32e40p_fetch_fifo_ctrl_if.sv
// OBI instruction-fetch port between the fetch controller (master) and instruction memory (slave).
interface cv32e40p_fetch_fifo_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/cv32e40p_fetch_fifo_ctrl.sv
// Instruction-fetch controller: issues sequential OBI word fetches under a credit limit, buffers
// responses in a small FIFO for the IF stage, and discards in-flight responses after a branch.
module cv32e40p_fetch_fifo_ctrl #(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_i,
  input  logic                              branch_i,
  input  logic [31:0]                       branch_addr_i,
  input  logic                              fetch_ready_i,
  output logic                              fetch_valid_o,
  output logic [31:0]                       fetch_rdata_o,
  output logic                              fetch_err_o,
  cv32e40p_fetch_fifo_ctrl_if.master        obi,
  output logic                              busy_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  typedef enum logic [0:0] {IDLE, WAIT_GNT} state_t;

  state_t           state;
  logic [31:0]      fetch_addr_q;
  logic [31:0]      pend_addr_q;
  logic             stale_q;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] outstanding_next;
  logic [OUT_W-1:0] discard_cnt;
  logic [OUT_W-1:0] discard_next;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [32:0]      mem [DEPTH];

  logic [SUM_W-1:0] kept_plus_count;
  logic             credit;
  logic             granted;
  logic             rsp;
  logic             rsp_drop;
  logic             push;
  logic             pop;
  logic [31:0]      branch_target;

  // Credit covers words already buffered plus in-flight words that will be kept.
  assign kept_plus_count = SUM_W'(outstanding - discard_cnt) + SUM_W'(count);
  assign credit = req_i && (kept_plus_count < SUM_W'(DEPTH))
                        && (outstanding < OUT_W'(MAX_OUTSTANDING));

  // A pending request keeps its own address so a branch cannot disturb it before grant.
  assign obi.req  = (state == WAIT_GNT) || credit;
  assign obi.addr = (state == WAIT_GNT) ? pend_addr_q : fetch_addr_q;
  assign granted  = obi.req && obi.gnt;

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
  assign rsp      = obi.rvalid && (outstanding != '0);
  assign rsp_drop = (discard_cnt != '0);
  assign push     = rsp && !rsp_drop && !branch_i;

  assign fetch_valid_o = (count != '0);
  assign pop           = fetch_valid_o && fetch_ready_i && !branch_i;
  assign fetch_rdata_o = fetch_valid_o ? mem[rd_ptr][31:0] : 32'h0;
  assign fetch_err_o   = fetch_valid_o && mem[rd_ptr][32];
  assign busy_o        = obi.req || (outstanding != '0);
  assign branch_target = branch_addr_i & 32'hFFFF_FFFC;

  always_comb begin
    outstanding_next = outstanding;
    if (granted && !rsp) begin
      outstanding_next = outstanding + 1'b1;
    end else if (!granted && rsp) begin
      outstanding_next = outstanding - 1'b1;
    end
  end

  // A branch marks everything in flight (including a grant this cycle) for discard; a stale
  // pending request granted later joins the discard set.
  always_comb begin
    discard_next = discard_cnt;
    if (branch_i) begin
      discard_next = outstanding_next;
    end else begin
      if (rsp && rsp_drop) begin
        discard_next = discard_next - 1'b1;
      end
      if (granted && stale_q) begin
        discard_next = discard_next + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      fetch_addr_q <= 32'h0;
      pend_addr_q  <= 32'h0;
      stale_q      <= 1'b0;
      outstanding  <= '0;
      discard_cnt  <= '0;
      count        <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
    end else begin
      outstanding <= outstanding_next;
      discard_cnt <= discard_next;

      case (state)
        IDLE: begin
          if (obi.req && !obi.gnt) begin
            state       <= WAIT_GNT;
            pend_addr_q <= fetch_addr_q;
            stale_q     <= branch_i;
          end
        end
        WAIT_GNT: begin
          if (obi.gnt) begin
            state   <= IDLE;
            stale_q <= 1'b0;
          end else if (branch_i) begin
            stale_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          stale_q <= 1'b0;
        end
      endcase

      if (branch_i) begin
        fetch_addr_q <= branch_target;
      end else if (granted && !stale_q) begin
        fetch_addr_q <= obi.addr + 32'd4;
      end

      if (branch_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {obi.err, obi.rdata};
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == CNT_W'(DEPTH))));
  assert property (@(posedge clk) disable iff (!rst_n) (discard_cnt <= outstanding));
endmodule

// File: tb/tb_cv32e40p_fetch_fifo_ctrl.sv
// Randomized bench for the fetch controller: a queue-based model of in-flight transactions and
// buffered words predicts the OBI request stream and the IF-side words every cycle.
module tb_cv32e40p_fetch_fifo_ctrl;
  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req;
  logic        branch;
  logic [31:0] branch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_rdata;
  logic        fetch_err;
  logic        busy;

  cv32e40p_fetch_fifo_ctrl_if obi();

  cv32e40p_fetch_fifo_ctrl #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .fetch_ready_i (fetch_ready),
    .fetch_valid_o (fetch_valid),
    .fetch_rdata_o (fetch_rdata),
    .fetch_err_o   (fetch_err),
    .obi           (obi),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        drop;
  } txn_t;

  txn_t        inflight[$];
  logic [32:0] words[$];
  logic [31:0] m_addr;
  logic [31:0] m_pend_addr;
  bit          m_pend;
  bit          m_pend_stale;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int p_gnt, p_rv, p_ready, p_branch, p_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16]} + 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == 32'h10) || (a[8:2] == 7'h55);
  endfunction

  function automatic int kept_inflight();
    int k = 0;
    foreach (inflight[i]) if (!inflight[i].drop) k++;
    return k;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(6))
      0: t = 32'h0000_0100;
      1: t = 32'h0000_0206;
      2: t = 32'h0000_0080;
      3: t = 32'h0000_0010;
      4: t = 32'hFFFF_FFF6;
      5: t = 32'hFFFF_FFF0;
      default: t = $urandom & 32'hFFFF_FFFE;
    endcase
    return t;
  endfunction

  task automatic set_profile(input int g, input int rv, input int rdy, input int br, input int rq);
    p_gnt = g; p_rv = rv; p_ready = rdy; p_branch = br; p_req = rq;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0; branch = 1'b0; branch_addr = 32'h0; fetch_ready = 1'b0;
    obi.gnt = 1'b0; obi.rvalid = 1'b0; obi.rdata = 32'h0; obi.err = 1'b0;
    #1;
    check("rst_instr_req", {31'h0, obi.req}, 32'h0);
    check("rst_instr_addr", obi.addr, 32'h0);
    check("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
    check("rst_fetch_rdata", fetch_rdata, 32'h0);
    check("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    inflight.delete();
    words.delete();
    m_addr = 32'h0; m_pend_addr = 32'h0; m_pend = 1'b0; m_pend_stale = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive inputs after the falling edge, compare outputs, then advance the model.
  task automatic step();
    bit          g, rv, e_credit, e_req, granted, rsp_push;
    logic [31:0] e_addr;
    logic [32:0] rsp_word;
    txn_t        t, nt;

    req         = ($urandom_range(99) < p_req);
    fetch_ready = ($urandom_range(99) < p_ready);
    branch      = ($urandom_range(99) < p_branch);
    branch_addr = pick_target();
    g           = ($urandom_range(99) < p_gnt);
    rv          = (inflight.size() != 0) && ($urandom_range(99) < p_rv);
    obi.gnt     = g;
    obi.rvalid  = rv;
    obi.rdata   = rv ? mem_data(inflight[0].addr) : $urandom;
    obi.err     = rv ? mem_err(inflight[0].addr) : 1'($urandom_range(1));
    #1;

    e_credit = req && (kept_inflight() + words.size() < DEPTH) && (inflight.size() < MAX_OUT);
    e_req    = m_pend || e_credit;
    e_addr   = m_pend ? m_pend_addr : m_addr;
    check("instr_req", {31'h0, obi.req}, {31'h0, e_req});
    if (e_req) check("instr_addr", obi.addr, e_addr);
    check("busy", {31'h0, busy}, {31'h0, e_req || (inflight.size() != 0)});
    check("fetch_valid", {31'h0, fetch_valid}, {31'h0, words.size() != 0});
    if (words.size() != 0) begin
      check("fetch_rdata", fetch_rdata, words[0][31:0]);
      check("fetch_err", {31'h0, fetch_err}, {31'h0, words[0][32]});
    end

    @(posedge clk);
    cycle++;
    granted  = e_req && g;
    rsp_push = 1'b0;
    rsp_word = '0;
    if (rv) begin
      t = inflight.pop_front();
      rsp_push = !t.drop && !branch;
      rsp_word = {mem_err(t.addr), mem_data(t.addr)};
    end
    if ((words.size() != 0) && fetch_ready && !branch) void'(words.pop_front());
    if (rsp_push) words.push_back(rsp_word);
    if (granted) begin
      nt.addr = e_addr;
      nt.drop = branch || (m_pend && m_pend_stale);
      inflight.push_back(nt);
    end
    if (branch) begin
      words.delete();
      foreach (inflight[i]) inflight[i].drop = 1'b1;
    end

    if (branch) m_addr = {branch_addr[31:2], 2'b00};
    else if (granted && !(m_pend && m_pend_stale)) m_addr = e_addr + 32'd4;

    if (e_req && !g) begin
      m_pend_stale = (m_pend && m_pend_stale) || branch;
      m_pend       = 1'b1;
      m_pend_addr  = e_addr;
    end else begin
      m_pend       = 1'b0;
      m_pend_stale = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    set_profile(100, 100, 100, 0, 100);  repeat (40)   step();
    set_profile(100, 100, 0, 0, 100);    repeat (12)   step();
    set_profile(100, 100, 15, 0, 100);   repeat (60)   step();
    set_profile(60, 70, 70, 5, 90);      repeat (800)  step();
    do_reset();
    set_profile(30, 40, 50, 10, 80);     repeat (1500) step();
    set_profile(20, 100, 100, 25, 100);  repeat (400)  step();
    set_profile(100, 100, 100, 3, 100);  repeat (400)  step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
